// File: rtl/wb4_to_pi1_pkg.sv
// Shared definitions for the Wishbone-to-PerInt bridge: PerInt op encodings,
// the bridge FSM states and a constant-foldable ceiling log2.
package wb4_to_pi1_pkg;

    localparam logic [1:0] PINOOP = 2'b00;
    localparam logic [1:0] PIWROP = 2'b01;
    localparam logic [1:0] PIRDOP = 2'b10;
    localparam logic [1:0] PIRWOP = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/wb4_to_pi1_fifo.sv
// Single-clock request FIFO with flush; head entry is always visible on dout.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module wb4_to_pi1_fifo
    import wb4_to_pi1_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = clog2(DEPTH);

    logic [PW:0]      wr_ptr_reg;
    logic [PW:0]      rd_ptr_reg;
    logic [WIDTH-1:0] mem_view [DEPTH];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign dout  = mem_view[rd_ptr_reg[PW-1:0]];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] entry_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else if (push && !full && (wr_ptr_reg[PW-1:0] == PW'(gi))) begin
                    entry_reg <= din;
                end
            end
            assign mem_view[gi] = entry_reg;
        end
    endgenerate

    // Flush discards everything not yet popped by catching the read pointer up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            if (push && !full) begin
                wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/wb4_to_pi1.sv
// Wishbone B4 pipelined slave that replays buffered requests as PerInt master ops,
// one at a time, returning in-order Wishbone acks once each pi1 op completes.
module wb4_to_pi1
    import wb4_to_pi1_pkg::*;
#(
    parameter int ARCHBITSZ = 16,
    parameter int FIFODEPTH = 2
) (
    input  logic                                     wb4_clk_i,
    input  logic                                     wb4_rst_ni,
    input  logic                                     wb4_cyc_i,
    input  logic                                     wb4_stb_i,
    input  logic                                     wb4_we_i,
    input  logic [ARCHBITSZ-1:0]                     wb4_addr_i,
    input  logic [ARCHBITSZ-1:0]                     wb4_data_i,
    input  logic [ARCHBITSZ/8-1:0]                   wb4_sel_i,
    output logic                                     wb4_stall_o,
    output logic                                     wb4_ack_o,
    output logic [ARCHBITSZ-1:0]                     wb4_data_o,
    output logic [1:0]                               pi1_op_o,
    output logic [ARCHBITSZ-clog2(ARCHBITSZ/8)-1:0]  pi1_addr_o,
    output logic [ARCHBITSZ-1:0]                     pi1_data_o,
    input  logic [ARCHBITSZ-1:0]                     pi1_data_i,
    output logic [ARCHBITSZ/8-1:0]                   pi1_sel_o,
    input  logic                                     pi1_rdy_i
);

    localparam int SW = ARCHBITSZ / 8;
    localparam int LB = clog2(SW);
    localparam int AW = ARCHBITSZ - LB;
    localparam int EW = 1 + AW + ARCHBITSZ + SW;

    state_e                 state_reg, state_next;
    logic                   op_hold_reg, op_hold_next;
    logic                   abort_reg, abort_next;
    logic                   ack_reg, ack_next;
    logic [ARCHBITSZ-1:0]   rdata_reg, rdata_next;

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [EW-1:0]          fifo_din, fifo_dout;
    logic                   head_we;
    logic [AW-1:0]          head_addr;
    logic [ARCHBITSZ-1:0]   head_data;
    logic [SW-1:0]          head_sel;
    logic                   work_pending;
    logic                   addr_lsb_unused;

    // Byte position within the word is carried entirely by sel.
    assign addr_lsb_unused = ^wb4_addr_i[LB-1:0];

    assign fifo_push = wb4_cyc_i && wb4_stb_i && !fifo_full;
    assign fifo_din  = {wb4_we_i, wb4_addr_i[ARCHBITSZ-1:LB], wb4_data_i, wb4_sel_i};
    assign fifo_pop  = (state_reg == ST_ISSUE) && wb4_cyc_i && pi1_rdy_i;
    assign {head_we, head_addr, head_data, head_sel} = fifo_dout;

    // A push in this cycle counts as pending so an empty bridge issues on the next cycle.
    assign work_pending = wb4_cyc_i && (!fifo_empty || fifo_push);

    assign wb4_stall_o = fifo_full;
    assign wb4_ack_o   = ack_reg && wb4_cyc_i;
    assign wb4_data_o  = rdata_reg;

    wb4_to_pi1_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk   (wb4_clk_i),
        .rst_n (wb4_rst_ni),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (!wb4_cyc_i),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge wb4_clk_i or negedge wb4_rst_ni) begin
        if (!wb4_rst_ni) begin
            state_reg   <= ST_IDLE;
            op_hold_reg <= 1'b0;
            abort_reg   <= 1'b0;
            ack_reg     <= 1'b0;
            rdata_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            op_hold_reg <= op_hold_next;
            abort_reg   <= abort_next;
            ack_reg     <= ack_next;
            rdata_reg   <= rdata_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_hold_next = op_hold_reg;
        abort_next   = abort_reg;
        ack_next     = 1'b0;
        rdata_next   = rdata_reg;
        pi1_op_o     = PINOOP;
        pi1_addr_o   = '0;
        pi1_data_o   = '0;
        pi1_sel_o    = '0;
        unique case (state_reg)
            ST_IDLE: begin
                if (work_pending) begin
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // A dropped cycle withdraws the op before the slave can take it.
                if (!wb4_cyc_i) begin
                    state_next = ST_IDLE;
                end else begin
                    pi1_op_o   = head_we ? PIWROP : PIRDOP;
                    pi1_addr_o = head_addr;
                    pi1_data_o = head_data;
                    pi1_sel_o  = head_sel;
                    if (pi1_rdy_i) begin
                        op_hold_next = head_we;
                        state_next   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (pi1_rdy_i) begin
                    abort_next = 1'b0;
                    if (wb4_cyc_i && !abort_reg) begin
                        ack_next = 1'b1;
                        if (!op_hold_reg) begin
                            rdata_next = pi1_data_i;
                        end
                    end
                    state_next = work_pending ? ST_ISSUE : ST_IDLE;
                end else if (!wb4_cyc_i) begin
                    abort_next = 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb4_to_pi1.sv
// Bench for wb4_to_pi1: table of single transactions plus hand-written multi-cycle
// sequences; a pi1 slave model and Wishbone ack scoreboard check every completion.
module tb_wb4_to_pi1;

    logic        wb4_clk_i = 1'b0;
    logic        wb4_rst_ni = 1'b0;
    logic        wb4_cyc_i = 1'b0;
    logic        wb4_stb_i = 1'b0;
    logic        wb4_we_i = 1'b0;
    logic [15:0] wb4_addr_i = '0;
    logic [15:0] wb4_data_i = '0;
    logic [1:0]  wb4_sel_i = '0;
    logic        wb4_stall_o;
    logic        wb4_ack_o;
    logic [15:0] wb4_data_o;
    logic [1:0]  pi1_op_o;
    logic [14:0] pi1_addr_o;
    logic [15:0] pi1_data_o;
    logic [15:0] pi1_data_i = '0;
    logic [1:0]  pi1_sel_o;
    logic        pi1_rdy_i = 1'b0;

    wb4_to_pi1 #(.ARCHBITSZ(16), .FIFODEPTH(2)) dut (
        .wb4_clk_i   (wb4_clk_i),
        .wb4_rst_ni  (wb4_rst_ni),
        .wb4_cyc_i   (wb4_cyc_i),
        .wb4_stb_i   (wb4_stb_i),
        .wb4_we_i    (wb4_we_i),
        .wb4_addr_i  (wb4_addr_i),
        .wb4_data_i  (wb4_data_i),
        .wb4_sel_i   (wb4_sel_i),
        .wb4_stall_o (wb4_stall_o),
        .wb4_ack_o   (wb4_ack_o),
        .wb4_data_o  (wb4_data_o),
        .pi1_op_o    (pi1_op_o),
        .pi1_addr_o  (pi1_addr_o),
        .pi1_data_o  (pi1_data_o),
        .pi1_data_i  (pi1_data_i),
        .pi1_sel_o   (pi1_sel_o),
        .pi1_rdy_i   (pi1_rdy_i)
    );

    always #5 wb4_clk_i = ~wb4_clk_i;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
        logic [1:0]  sel;
        int          iw;
        int          cw;
        logic [1:0]  exp_op;
        logic [14:0] exp_waddr;
        logic [15:0] exp_rdata;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [14:0] waddr;
        logic [15:0] data;
        logic [1:0]  sel;
    } op_exp_t;

    typedef struct {
        logic        we;
        logic [15:0] rdata;
    } ack_exp_t;

    vec_t     vecs [5];
    op_exp_t  exp_op_q [$];
    ack_exp_t exp_ack_q [$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc_cnt = 0;
    int push_cyc = 0;
    int first_op_cyc = 0;
    int last_ack_cyc = 0;
    int n_ops = 0;
    int n_acks = 0;
    int n_cplts = 0;
    int issue_wait = 0;
    int cplt_wait = 0;
    int sl_phase = 0;
    int sl_cnt = 0;
    logic [14:0] sl_addr = '0;
    logic        stall_seen = 1'b0;
    op_exp_t     snap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    // Slave read data depends only on the word address.
    function automatic logic [15:0] rd_val(input logic [14:0] w);
        return 16'hBEEF ^ {1'b0, w ^ 15'h0008};
    endfunction

    always @(posedge wb4_clk_i) cyc_cnt++;

    // Monitor and pi1 slave model: observe mid-cycle, choose rdy for the coming edge.
    always @(negedge wb4_clk_i) begin
        if (!wb4_rst_ni) begin
            pi1_rdy_i = 1'b0;
            sl_phase = 0;
            sl_cnt = 0;
        end else begin
            if (wb4_stall_o) stall_seen = 1'b1;
            chk("op_not_rw", pi1_op_o != 2'b11, 1'b1);
            if (wb4_ack_o) begin
                chk("ack_only_in_cyc", wb4_cyc_i, 1'b1);
                chk("ack_expected", exp_ack_q.size() > 0, 1'b1);
                if (exp_ack_q.size() > 0) begin
                    ack_exp_t a;
                    a = exp_ack_q.pop_front();
                    if (!a.we) chk("ack_rdata", wb4_data_o, a.rdata);
                end
                n_acks++;
                last_ack_cyc = cyc_cnt;
            end
            if (sl_phase == 0) begin
                if (pi1_op_o != 2'b00) begin
                    if (sl_cnt == 0) begin
                        snap = '{op: pi1_op_o, waddr: pi1_addr_o, data: pi1_data_o, sel: pi1_sel_o};
                    end else begin
                        chk("hold_op", pi1_op_o, snap.op);
                        chk("hold_addr", pi1_addr_o, snap.waddr);
                        chk("hold_data", pi1_data_o, snap.data);
                        chk("hold_sel", pi1_sel_o, snap.sel);
                    end
                    if (sl_cnt < issue_wait) begin
                        pi1_rdy_i = 1'b0;
                        sl_cnt++;
                    end else begin
                        pi1_rdy_i = 1'b1;
                        chk("op_expected", exp_op_q.size() > 0, 1'b1);
                        if (exp_op_q.size() > 0) begin
                            op_exp_t e;
                            e = exp_op_q.pop_front();
                            chk("pi1_op", pi1_op_o, e.op);
                            chk("pi1_addr", pi1_addr_o, e.waddr);
                            chk("pi1_data", pi1_data_o, e.data);
                            chk("pi1_sel", pi1_sel_o, e.sel);
                        end
                        sl_addr = pi1_addr_o;
                        first_op_cyc = cyc_cnt;
                        n_ops++;
                        sl_phase = 1;
                        sl_cnt = 0;
                    end
                end else begin
                    pi1_rdy_i = 1'b0;
                    sl_cnt = 0;
                end
            end else begin
                if (sl_cnt < cplt_wait) begin
                    pi1_rdy_i = 1'b0;
                    sl_cnt++;
                end else begin
                    pi1_rdy_i = 1'b1;
                    pi1_data_i = rd_val(sl_addr);
                    n_cplts++;
                    sl_phase = 0;
                    sl_cnt = 0;
                end
            end
        end
    end

    // Presents one request and holds it until accepted; expectations are queued at acceptance.
    task automatic wb_req(input logic we, input logic [15:0] addr, input logic [15:0] data,
                          input logic [1:0] sel, input logic [1:0] exp_op,
                          input logic [14:0] exp_waddr, input logic [15:0] exp_rdata);
        int t;
        t = 0;
        wb4_cyc_i = 1'b1;
        wb4_stb_i = 1'b1;
        wb4_we_i = we;
        wb4_addr_i = addr;
        wb4_data_i = data;
        wb4_sel_i = sel;
        @(negedge wb4_clk_i);
        while (wb4_stall_o && t < 100) begin
            @(negedge wb4_clk_i);
            t++;
        end
        if (t >= 100) fail_timeout("wb_req_stall");
        push_cyc = cyc_cnt;
        exp_op_q.push_back('{op: exp_op, waddr: exp_waddr, data: data, sel: sel});
        exp_ack_q.push_back('{we: we, rdata: exp_rdata});
        @(posedge wb4_clk_i);
        #1;
    endtask

    task automatic wb_idle(input logic cyc);
        wb4_cyc_i = cyc;
        wb4_stb_i = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((exp_op_q.size() != 0 || exp_ack_q.size() != 0 || sl_phase != 0) && t < 300) begin
            @(negedge wb4_clk_i);
            t++;
        end
        if (t >= 300) fail_timeout(name);
        repeat (3) @(negedge wb4_clk_i);
        @(posedge wb4_clk_i);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int t;
        t = 0;
        while (sl_phase != 1 && t < 50) begin
            @(negedge wb4_clk_i);
            t++;
        end
        if (t >= 50) fail_timeout(name);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ack"}, wb4_ack_o, 1'b0);
        chk({tag, "_rdata"}, wb4_data_o, 16'h0000);
        chk({tag, "_stall"}, wb4_stall_o, 1'b0);
        chk({tag, "_op"}, pi1_op_o, 2'b00);
        chk({tag, "_addr"}, pi1_addr_o, 15'h0000);
        chk({tag, "_data"}, pi1_data_o, 16'h0000);
        chk({tag, "_sel"}, pi1_sel_o, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, o0, c0;
        vecs[0] = '{we:1'b0, addr:16'h0010, data:16'h0000, sel:2'b11, iw:0, cw:0, exp_op:2'b10, exp_waddr:15'h0008, exp_rdata:16'hBEEF};
        vecs[1] = '{we:1'b1, addr:16'h0021, data:16'h1234, sel:2'b10, iw:0, cw:0, exp_op:2'b01, exp_waddr:15'h0010, exp_rdata:16'h0000};
        vecs[2] = '{we:1'b0, addr:16'hFFFE, data:16'h5A5A, sel:2'b01, iw:3, cw:2, exp_op:2'b10, exp_waddr:15'h7FFF, exp_rdata:16'hC118};
        vecs[3] = '{we:1'b1, addr:16'h8000, data:16'hA55A, sel:2'b11, iw:1, cw:3, exp_op:2'b01, exp_waddr:15'h4000, exp_rdata:16'h0000};
        vecs[4] = '{we:1'b0, addr:16'h1235, data:16'h0F0F, sel:2'b11, iw:0, cw:1, exp_op:2'b10, exp_waddr:15'h091A, exp_rdata:16'hB7FD};

        @(negedge wb4_clk_i);
        check_reset_outs("reset");
        #2 wb4_rst_ni = 1'b1;
        @(posedge wb4_clk_i);
        #1;

        for (int i = 0; i < 5; i++) begin
            issue_wait = vecs[i].iw;
            cplt_wait = vecs[i].cw;
            a0 = n_acks;
            wb_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].sel,
                   vecs[i].exp_op, vecs[i].exp_waddr, vecs[i].exp_rdata);
            wb_idle(1'b1);
            drain("vec_drain");
            chk($sformatf("vec%0d_ack_count", i), n_acks - a0, 1);
            if (i == 0) begin
                chk("t1_op_latency", first_op_cyc - push_cyc, 1);
                chk("t1_ack_latency", last_ack_cyc - push_cyc, 3);
            end
        end

        // Four back-to-back writes against a slow-completing slave.
        issue_wait = 0;
        cplt_wait = 5;
        a0 = n_acks;
        o0 = n_ops;
        stall_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wb_req(1'b1, 16'h0100 + 16'(2 * k), 16'h1111 * 16'(k + 1), 2'b11,
                   2'b01, 15'h0080 + 15'(k), 16'h0000);
        end
        wb_idle(1'b1);
        drain("t3_drain");
        chk("t3_stall_seen", stall_seen, 1'b1);
        chk("t3_ops", n_ops - o0, 4);
        chk("t3_acks", n_acks - a0, 4);
        chk("t3_stall_clear", wb4_stall_o, 1'b0);

        // Drop the cycle while the first of three reads is outstanding on pi1.
        issue_wait = 0;
        cplt_wait = 6;
        a0 = n_acks;
        o0 = n_ops;
        c0 = n_cplts;
        for (int k = 0; k < 3; k++) begin
            wb_req(1'b0, 16'h0200 + 16'(2 * k), 16'h0000, 2'b11,
                   2'b10, 15'h0100 + 15'(k), rd_val(15'h0100 + 15'(k)));
        end
        chk("t5_in_wait", sl_phase, 1);
        wb_idle(1'b0);
        exp_op_q.delete();
        exp_ack_q.delete();
        repeat (15) @(negedge wb4_clk_i);
        chk("t5_ops", n_ops - o0, 1);
        chk("t5_completed", n_cplts - c0, 1);
        chk("t5_acks", n_acks - a0, 0);
        chk("t5_idle_op", pi1_op_o, 2'b00);
        chk("t5_stall", wb4_stall_o, 1'b0);
        @(posedge wb4_clk_i);
        #1;
        cplt_wait = 0;
        a0 = n_acks;
        wb_req(1'b0, 16'h0010, 16'h0000, 2'b11, 2'b10, 15'h0008, 16'hBEEF);
        wb_idle(1'b1);
        drain("t5_after_drain");
        chk("t5_after_acks", n_acks - a0, 1);

        // Asynchronous reset while an op waits for completion.
        cplt_wait = 8;
        wb_req(1'b0, 16'h0042, 16'h0000, 2'b11, 2'b10, 15'h0021, rd_val(15'h0021));
        wb_idle(1'b1);
        wait_busy("t6_busy");
        @(posedge wb4_clk_i);
        #3 wb4_rst_ni = 1'b0;
        #1;
        check_reset_outs("t6_async_reset");
        exp_op_q.delete();
        exp_ack_q.delete();
        @(negedge wb4_clk_i);
        #2 wb4_rst_ni = 1'b1;
        @(posedge wb4_clk_i);
        #1;
        cplt_wait = 0;
        a0 = n_acks;
        wb_req(1'b0, 16'h0010, 16'h0000, 2'b11, 2'b10, 15'h0008, 16'hBEEF);
        wb_idle(1'b1);
        drain("t6_after_drain");
        chk("t6_after_acks", n_acks - a0, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
